bp_pht_scheduler: RTL and testbench

Sequencer and arbiter for the branch predictor's single-port pattern history table (PHT) of 2-bit saturating counters, indexed by PC XOR global history.
- Shares the PHT port between fetch-stage prediction lookups and execute-stage resolution updates. Updates are buffered in a small queue.
- Performs the post-reset table initialisation sweep.
- Owns the speculative global history register, including mispredict restore.
- Sits between fetch, execute and the PHT SRAM macro.

---
 rtl/bp_pht_scheduler_if.sv | 49 ++++
 rtl/bp_pht_scheduler.sv | 165 ++++++++++++++++
 tb/tb_bp_pht_scheduler.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_pht_scheduler_if.sv
// Fetch, execute and PHT-macro signals of the PHT scheduler bundled as one interface.
// The slave modport is taken by the scheduler; master is the surrounding pipeline/SRAM side.
interface bp_pht_scheduler_if #(
  parameter int PC_WIDTH = 32,
  parameter int IDX_BITS = 12
);
  logic                pred_req;
  logic [PC_WIDTH-1:0] pred_pc;
  logic                pred_gnt;
  logic                pred_valid;
  logic                pred_taken;
  logic [IDX_BITS-1:0] pred_hist;

  logic                upd_valid;
  logic [PC_WIDTH-1:0] upd_pc;
  logic [IDX_BITS-1:0] upd_hist;
  logic                upd_taken;
  logic                upd_mispredict;
  logic                upd_ready;

  logic                pht_en;
  logic                pht_we;
  logic [IDX_BITS-1:0] pht_addr;
  logic [1:0]          pht_wdata;
  logic [1:0]          pht_rdata;

  logic [IDX_BITS-1:0] ghist;
  logic                init_busy;

  modport master (
    output pred_req, pred_pc,
    input  pred_gnt, pred_valid, pred_taken, pred_hist,
    output upd_valid, upd_pc, upd_hist, upd_taken, upd_mispredict,
    input  upd_ready,
    input  pht_en, pht_we, pht_addr, pht_wdata,
    output pht_rdata,
    input  ghist, init_busy
  );

  modport slave (
    input  pred_req, pred_pc,
    output pred_gnt, pred_valid, pred_taken, pred_hist,
    input  upd_valid, upd_pc, upd_hist, upd_taken, upd_mispredict,
    output upd_ready,
    output pht_en, pht_we, pht_addr, pht_wdata,
    input  pht_rdata,
    output ghist, init_busy
  );
endinterface

// File: rtl/bp_pht_scheduler.sv
// Arbiter/sequencer for the single-port PHT: init sweep, fetch lookups, queued
// execute updates (read-modify-write of 2-bit counters) and speculative global history.
module bp_pht_scheduler #(
  parameter int PC_WIDTH = 32,
  parameter int IDX_BITS = 12,
  parameter int UQ_DEPTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  bp_pht_scheduler_if.slave  bus
);
  localparam int PW = $clog2(UQ_DEPTH);
  localparam logic [PW:0] QFULL = (PW+1)'(UQ_DEPTH);

  typedef enum logic [1:0] {INIT, IDLE, PRED_RSP, UPD_WR} state_t;

  state_t              state;
  logic [IDX_BITS-1:0] sweep_cnt;
  logic [IDX_BITS-1:0] ghist_q;
  logic [IDX_BITS-1:0] pred_hist_q;
  logic                pred_taken_q;

  logic [IDX_BITS-1:0] q_idx   [UQ_DEPTH];
  logic [IDX_BITS-1:0] q_hist  [UQ_DEPTH];
  logic                q_taken [UQ_DEPTH];
  logic                q_misp  [UQ_DEPTH];
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [PW:0]         count;

  logic                q_full;
  logic                q_empty;
  logic                enq;
  logic                pop;
  logic                grant;
  logic                issue_upd;
  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] head_idx;
  logic [IDX_BITS-1:0] head_hist;
  logic                head_taken;
  logic                head_misp;
  logic [1:0]          next_ctr;

  assign q_full     = (count == QFULL);
  assign q_empty    = (count == '0);
  assign head_idx   = q_idx[rd_ptr];
  assign head_hist  = q_hist[rd_ptr];
  assign head_taken = q_taken[rd_ptr];
  assign head_misp  = q_misp[rd_ptr];
  assign pred_idx   = bus.pred_pc[IDX_BITS-1:0] ^ ghist_q;

  // A full queue pre-empts fetch so execute can never be starved by back-to-back lookups.
  assign issue_upd  = (state == IDLE) && (q_full || (!bus.pred_req && !q_empty));
  assign grant      = (state == IDLE) && bus.pred_req && !q_full;
  assign pop        = (state == UPD_WR);

  assign bus.upd_ready = (state != INIT) && !q_full;
  assign enq           = bus.upd_valid && bus.upd_ready;

  always_comb begin
    next_ctr = bus.pht_rdata;
    if (head_taken) begin
      if (bus.pht_rdata != 2'b11) next_ctr = bus.pht_rdata + 2'd1;
    end else begin
      if (bus.pht_rdata != 2'b00) next_ctr = bus.pht_rdata - 2'd1;
    end
  end

  // INIT outputs are gated by rst_n so the macro sees no enable while reset is held.
  always_comb begin
    bus.pht_en    = 1'b0;
    bus.pht_we    = 1'b0;
    bus.pht_addr  = '0;
    bus.pht_wdata = '0;
    unique case (state)
      INIT: begin
        bus.pht_en    = rst_n;
        bus.pht_we    = rst_n;
        bus.pht_addr  = sweep_cnt;
        bus.pht_wdata = 2'b10;
      end
      IDLE: begin
        if (issue_upd) begin
          bus.pht_en   = 1'b1;
          bus.pht_addr = head_idx;
        end else if (grant) begin
          bus.pht_en   = 1'b1;
          bus.pht_addr = pred_idx;
        end
      end
      UPD_WR: begin
        bus.pht_en    = 1'b1;
        bus.pht_we    = 1'b1;
        bus.pht_addr  = head_idx;
        bus.pht_wdata = next_ctr;
      end
      default: ;
    endcase
  end

  assign bus.pred_gnt   = grant;
  assign bus.pred_valid = (state == PRED_RSP);
  assign bus.pred_taken = (state == PRED_RSP) ? bus.pht_rdata[1] : pred_taken_q;
  assign bus.pred_hist  = pred_hist_q;
  assign bus.ghist      = ghist_q;
  assign bus.init_busy  = (state == INIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT;
      sweep_cnt    <= '0;
      ghist_q      <= '0;
      pred_hist_q  <= '0;
      pred_taken_q <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      for (int unsigned i = 0; i < UQ_DEPTH; i++) begin
        q_idx[i]   <= '0;
        q_hist[i]  <= '0;
        q_taken[i] <= 1'b0;
        q_misp[i]  <= 1'b0;
      end
    end else begin
      unique case (state)
        INIT: begin
          sweep_cnt <= sweep_cnt + IDX_BITS'(1);
          if (sweep_cnt == '1) state <= IDLE;
        end
        IDLE: begin
          if (issue_upd) begin
            state <= UPD_WR;
          end else if (grant) begin
            pred_hist_q <= ghist_q;
            state       <= PRED_RSP;
          end
        end
        PRED_RSP: begin
          pred_taken_q <= bus.pht_rdata[1];
          ghist_q      <= {ghist_q[IDX_BITS-2:0], bus.pht_rdata[1]};
          state        <= IDLE;
        end
        UPD_WR: begin
          if (head_misp) ghist_q <= {head_hist[IDX_BITS-2:0], head_taken};
          state <= IDLE;
        end
        default: state <= INIT;
      endcase

      if (enq) begin
        q_idx[wr_ptr]   <= bus.upd_pc[IDX_BITS-1:0] ^ bus.upd_hist;
        q_hist[wr_ptr]  <= bus.upd_hist;
        q_taken[wr_ptr] <= bus.upd_taken;
        q_misp[wr_ptr]  <= bus.upd_mispredict;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({enq, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bp_pht_scheduler.sv
// Bench for bp_pht_scheduler: directed steps plus random traffic checked against a
// transaction-level model of the PHT contents, update queue and global history.
module tb_bp_pht_scheduler;
  logic clk;
  logic rst_n;

  bp_pht_scheduler_if #(.PC_WIDTH(32), .IDX_BITS(12)) bus ();

  bp_pht_scheduler #(.PC_WIDTH(32), .IDX_BITS(12), .UQ_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro stand-in: read data appears the cycle after the read.
  logic [1:0] mem [4096];
  always @(posedge clk) begin
    if (bus.pht_en) begin
      if (bus.pht_we) mem[bus.pht_addr] <= bus.pht_wdata;
      else            bus.pht_rdata     <= mem[bus.pht_addr];
    end
  end

  typedef struct packed {
    logic [11:0] idx;
    logic        taken;
    logic        misp;
    logic [11:0] hist;
  } upd_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [1:0]  ref_pht [4096];
  logic [11:0] ref_ghist;
  logic [11:0] ref_pred_hist;
  logic        ref_taken;
  logic [11:0] ref_pend;
  int          ref_phase;   // 0: port free, 1: lookup response due, 2: update write due
  upd_t        ref_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4096; i++) ref_pht[i] = 2'b10;
    ref_ghist     = '0;
    ref_pred_hist = '0;
    ref_taken     = 1'b0;
    ref_pend      = '0;
    ref_phase     = 0;
    ref_q.delete();
  endtask

  task automatic reset_check();
    chk("rst_ctrl", {bus.pred_gnt, bus.pred_valid, bus.upd_ready, bus.pht_en, bus.pht_we, bus.init_busy},
        6'b000001);
    chk("rst_ghist", bus.ghist, 0);
    chk("rst_pred_hist", bus.pred_hist, 0);
    chk("rst_pred_taken", bus.pred_taken, 0);
  endtask

  task automatic sweep(input int n);
    for (int a = 0; a < n; a++) begin
      @(negedge clk);
      chk("sweep", {bus.init_busy, bus.pht_en, bus.pht_we, bus.pred_gnt, bus.upd_ready, bus.pht_wdata, bus.pht_addr},
          {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 12'(a)});
      @(posedge clk); #1;
    end
  endtask

  // Checks one post-init cycle at the negedge and advances the model across the next edge.
  task automatic model_cycle();
    int   qs, c, nc, nxt;
    logic exp_ready;
    logic [11:0] a;
    upd_t h, e;
    qs        = ref_q.size();
    exp_ready = (qs < 4);
    nxt       = 0;
    chk("init_busy", bus.init_busy, 0);
    chk("upd_ready", bus.upd_ready, exp_ready);
    chk("ghist", bus.ghist, ref_ghist);
    chk("pred_hist", bus.pred_hist, ref_pred_hist);
    case (ref_phase)
      0: begin
        chk("pred_valid_idle", bus.pred_valid, 0);
        chk("pred_taken_hold", bus.pred_taken, ref_taken);
        if (qs == 4 || (!bus.pred_req && qs > 0)) begin
          chk("upd_read", {bus.pred_gnt, bus.pht_en, bus.pht_we, bus.pht_addr}, {3'b010, ref_q[0].idx});
          nxt = 2;
        end else if (bus.pred_req) begin
          a = bus.pred_pc[11:0] ^ ref_ghist;
          chk("pred_read", {bus.pred_gnt, bus.pht_en, bus.pht_we, bus.pht_addr}, {3'b110, a});
          ref_pend      = a;
          ref_pred_hist = ref_ghist;
          nxt = 1;
        end else begin
          chk("no_access", {bus.pred_gnt, bus.pht_en}, 0);
        end
      end
      1: begin
        chk("pred_rsp", {bus.pred_valid, bus.pred_gnt, bus.pht_en}, 3'b100);
        ref_taken = ref_pht[ref_pend][1];
        chk("pred_taken", bus.pred_taken, ref_taken);
        ref_ghist = {ref_ghist[10:0], ref_taken};
      end
      default: begin
        h  = ref_q.pop_front();
        c  = int'(ref_pht[h.idx]);
        nc = h.taken ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
        chk("upd_write", {bus.pred_gnt, bus.pht_en, bus.pht_we, bus.pht_addr, bus.pht_wdata},
            {3'b011, h.idx, 2'(nc)});
        ref_pht[h.idx] = 2'(nc);
        if (h.misp) ref_ghist = {h.hist[10:0], h.taken};
      end
    endcase
    if (bus.upd_valid && exp_ready) begin
      e.idx   = bus.upd_pc[11:0] ^ bus.upd_hist;
      e.taken = bus.upd_taken;
      e.misp  = bus.upd_mispredict;
      e.hist  = bus.upd_hist;
      ref_q.push_back(e);
    end
    ref_phase = nxt;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk); #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [11:0] hist, input logic tk, input logic mp);
    bus.upd_valid      = 1'b1;
    bus.upd_pc         = pc;
    bus.upd_hist       = hist;
    bus.upd_taken      = tk;
    bus.upd_mispredict = mp;
    step();
    bus.upd_valid = 1'b0;
  endtask

  logic       seq_taken [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       hit;

  initial begin
    rst_n              = 1'b1;
    bus.pred_req       = 1'b0;
    bus.pred_pc        = '0;
    bus.upd_valid      = 1'b0;
    bus.upd_pc         = '0;
    bus.upd_hist       = '0;
    bus.upd_taken      = 1'b0;
    bus.upd_mispredict = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_check();
    @(posedge clk); @(posedge clk); #1;
    reset_check();

    // Sweep with fetch already requesting; interrupt it at 0x800 and restart.
    bus.pred_req = 1'b1;
    bus.pred_pc  = 32'h0000_0ABC;
    rst_n = 1'b1;
    sweep(12'h800);
    @(negedge clk);
    chk("sweep_at_800", bus.pht_addr, 12'h800);
    rst_n = 1'b0;
    #1 reset_check();
    @(posedge clk); #1;
    rst_n = 1'b1;
    sweep(4096);
    model_reset();

    // First lookups after init: 0xABC then 0xABD once history has shifted.
    step();
    step();
    chk("ghist_after_first_pred", bus.ghist, 12'h001);
    chk("pred_taken_first", bus.pred_taken, 1);
    step();
    step();
    bus.pred_req = 1'b0;
    step();

    // Saturating counter walk on idx 0x013: 2->3->3->2->1->0->0.
    for (int i = 0; i < 6; i++) begin
      offer(32'h10, 12'h003, seq_taken[i], 1'b0);
      step();
      step();
    end

    // Fill the queue while fetch keeps requesting; full queue must win the port.
    bus.pred_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.pred_pc = $urandom;
      offer($urandom, 12'($urandom), 1'($urandom), 1'b0);
      bus.upd_valid = 1'b1;
    end
    bus.upd_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    bus.pred_req = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // Mispredict restore overrides speculative history.
    offer(32'h0000_1234, 12'h55E, 1'b0, 1'b1);
    step();
    step();
    chk("ghist_restore_abc", bus.ghist, 12'hABC);
    offer(32'h0000_0040, 12'h0F0, 1'b0, 1'b1);
    step();
    step();
    chk("ghist_restore_1e0", bus.ghist, 12'h1E0);

    // Random mixed traffic.
    for (int i = 0; i < 800; i++) begin
      bus.pred_req       = ($urandom_range(99) < 60);
      bus.pred_pc        = $urandom;
      bus.upd_valid      = ($urandom_range(99) < 40);
      bus.upd_pc         = $urandom;
      bus.upd_hist       = 12'($urandom);
      bus.upd_taken      = 1'($urandom);
      bus.upd_mispredict = ($urandom_range(99) < 10);
      step();
    end

    // Reset landing in the update write cycle.
    bus.pred_req  = 1'b0;
    bus.upd_valid = 1'b0;
    step();
    step();
    offer(32'h0000_0777, 12'h111, 1'b1, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ref_phase == 2) begin
        hit = 1'b1;
        break;
      end
      model_cycle();
      @(posedge clk); #1;
    end
    chk("reached_upd_wr", hit, 1);
    rst_n = 1'b0;
    #1 reset_check();
    @(posedge clk); #1;
    rst_n = 1'b1;
    sweep(4096);
    model_reset();
    for (int i = 0; i < 4; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
